load_extend_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/load_extract.sv | 41 ++++
 rtl/load_extend_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_extend_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the load path of the P7 MIPS CPU.
//   ld_op_t       - load op codes as presented by the MEM stage (3 bits)
//   state_t       - load_extend_unit FSM states
//   ld_op_valid   - true for the five real load ops (110/111 count as none)
//   ld_misaligned - address-error check for lw / lh / lhu
package cpu_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LW   = 3'd1,
    LD_LB   = 3'd2,
    LD_LBU  = 3'd3,
    LD_LH   = 3'd4,
    LD_LHU  = 3'd5
  } ld_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic logic ld_op_valid(input logic [2:0] op);
    return (op >= 3'(LD_LW)) && (op <= 3'(LD_LHU));
  endfunction

  // Words must be 4-byte aligned, halfwords 2-byte aligned; bytes never fault.
  function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (op == 3'(LD_LW))
      bad = (off != 2'b00);
    else if ((op == 3'(LD_LH)) || (op == 3'(LD_LHU)))
      bad = off[0];
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational byte/halfword lane select plus sign/zero extension.
//   op    in  3   load op code (cpu_pkg::ld_op_t values)
//   off   in  2   byte offset within the word (latched addr[1:0])
//   rdata in  32  full word from the bus
//   data  out 32  extended result
// Halfwords are selected by off[1] only, so a misaligned halfword (off[0]=1)
// returns the halfword that contains the addressed byte's aligned pair.
module load_extract
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (op)
      3'(LD_LB):  data = {{24{byte_sel[7]}}, byte_sel};
      3'(LD_LBU): data = {24'd0, byte_sel};
      3'(LD_LH):  data = {{16{half_sel[15]}}, half_sel};
      3'(LD_LHU): data = {16'd0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/load_extend_unit.sv
// load_extend_unit: load side of the MEM/WB data path.
// Accepts a load from MEM, issues a word-aligned bus read (req/gnt, then
// rvalid), extracts and extends the addressed byte/halfword and pulses it to WB.
// busy stalls the pipeline whenever the FSM is out of IDLE.
//
// Handshakes: a load is accepted on a clock edge where req_valid=1, req_ready=1,
// flush=0 and req_op is a real load. bus_req stays high with bus_addr stable
// until an edge with bus_gnt=1. bus_rdata is taken only on an edge with
// bus_rvalid=1 while in DATA (kept) or DRAIN (discarded); rvalid elsewhere is
// ignored. wb_valid is a single-cycle pulse; wb_data/wb_rd hold afterwards.
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready/req_op/req_addr/req_rd  - load request from MEM
//   flush                                       - kill the in-flight load
//   bus_req/bus_addr/bus_gnt/bus_rvalid/bus_rdata - memory read bus
//   wb_valid/wb_data/wb_rd                      - result to WB
//   busy                                        - pipeline stall request
//   exc_adel/exc_badvaddr                       - address error (LOAD_ADEL_EN only)
//   dbg_state                                   - current FSM state
//
// Build option: define LOAD_ADEL_EN to enable the misalignment check and the
// exc_adel/exc_badvaddr ports. Without it, misaligned addresses are truncated
// on the bus and extracted at the given offset.
module load_extend_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_rd,
  input  logic              flush,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              busy,
`ifdef LOAD_ADEL_EN
  output logic              exc_adel,
  output logic [ADDR_W-1:0] exc_badvaddr,
`endif
  output logic [2:0]        dbg_state
);

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic              accept;
  logic              capture;
  logic [31:0]       ext_data;

`ifdef LOAD_ADEL_EN
  logic              adel;
  logic              adel_q;
  logic [ADDR_W-1:0] badvaddr_q;
`endif

  load_extract u_extract (
    .op    (op_q),
    .off   (addr_q[1:0]),
    .rdata (bus_rdata),
    .data  (ext_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state. flush wins over everything except an rvalid already owed to
  // DRAIN: a granted-then-flushed read must still be drained off the bus.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
`ifdef LOAD_ADEL_EN
    adel    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!flush && req_valid && ld_op_valid(req_op)) begin
          accept  = 1'b1;
          state_d = ST_ADDR;
`ifdef LOAD_ADEL_EN
          // Faulting loads skip the bus entirely and report straight away.
          if (ld_misaligned(req_op, req_addr[1:0])) begin
            adel    = 1'b1;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_ADDR: begin
        if (bus_gnt)    state_d = flush ? ST_DRAIN : ST_DATA;
        else if (flush) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (bus_rvalid) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            capture = 1'b1;
            state_d = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus_rvalid) state_d = ST_IDLE;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= 3'(LD_NONE);
      addr_q     <= '0;
      rd_q       <= '0;
      wb_data    <= '0;
      wb_rd      <= '0;
`ifdef LOAD_ADEL_EN
      adel_q     <= 1'b0;
      badvaddr_q <= '0;
`endif
    end else begin
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        rd_q   <= req_rd;
      end
      if (capture) begin
        wb_data <= ext_data;
        wb_rd   <= rd_q;
      end
`ifdef LOAD_ADEL_EN
      if (accept) adel_q <= adel;
      if (adel) begin
        wb_data    <= '0;
        wb_rd      <= req_rd;
        badvaddr_q <= req_addr;
      end
`endif
    end
  end

  // Outputs decoded from the state register; wb_valid is additionally
  // masked by flush so an older-stage exception kills the writeback.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign bus_req   = (state_q == ST_ADDR);
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign wb_valid  = (state_q == ST_RESP) && !flush;
  assign dbg_state = state_q;

`ifdef LOAD_ADEL_EN
  assign exc_adel     = adel_q;
  assign exc_badvaddr = badvaddr_q;
`endif

endmodule

// File: tb/tb_load_extend_unit.sv
// tb_load_extend_unit: directed bench for load_extend_unit.
// Driver tasks present loads and play the bus; each accepted load pushes its
// expected result (data, rd, cycle of wb_valid, exc flag) into exp_q. A
// monitor pops and compares whenever wb_valid is seen. Define LOAD_ADEL_EN
// to also exercise the address-error path.
module tb_load_extend_unit;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] IDLE_RDATA = 32'h5555_5555;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [4:0]    req_rd = '0;
  logic          flush = 1'b0;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic          bus_gnt = 1'b0;
  logic          bus_rvalid = 1'b0;
  logic [DW-1:0] bus_rdata = IDLE_RDATA;
  logic          wb_valid;
  logic [31:0]   wb_data;
  logic [4:0]    wb_rd;
  logic          busy;
  logic [2:0]    dbg_state;
`ifdef LOAD_ADEL_EN
  logic          exc_adel;
  logic [AW-1:0] exc_badvaddr;
`endif

  load_extend_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_rd       (req_rd),
    .flush        (flush),
    .bus_req      (bus_req),
    .bus_addr     (bus_addr),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .busy         (busy),
`ifdef LOAD_ADEL_EN
    .exc_adel     (exc_adel),
    .exc_badvaddr (exc_badvaddr),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 20000", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // {exc[53], rd[52:48], wb cycle[47:32], data[31:0]}
  logic [53:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [4:0] rd, input int wcyc,
                          input logic exc);
    exp_q.push_back({exc, rd, 16'(wcyc), data});
  endtask

  // Monitor: every wb_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [53:0] e;
    if (reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk1("spurious_wb_valid", wb_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e[31:0]);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[52:48]});
        chk("wb_cycle", {16'd0, 16'(cyc)}, {16'd0, e[47:32]});
`ifdef LOAD_ADEL_EN
        chk1("exc_adel", exc_adel, e[53]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load through a well-behaved bus: gd cycles of grant wait and rvd
  // cycles of data wait. wb_valid is expected at c0 + 3 + gd + rvd.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input int gd, input int rvd, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
    int c0;
    step();
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_rd = rd;
    c0 = cyc;
    push_exp(exp_data, rd, c0 + 3 + gd + rvd, 1'b0);
    step();
    req_valid = 1'b0; req_op = 3'd0;
    for (int i = 0; i < gd; i++) begin
      chk1("bus_req_wait", bus_req, 1'b1);
      chk1("busy_gnt_wait", busy, 1'b1);
      step();
    end
    chk1("bus_req", bus_req, 1'b1);
    chk1("busy_gnt", busy, 1'b1);
    chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    for (int i = 0; i < rvd; i++) begin
      chk1("busy_data_wait", busy, 1'b1);
      step();
    end
    chk1("busy_data", busy, 1'b1);
    bus_rvalid = 1'b1; bus_rdata = rdata;
    step();
    bus_rvalid = 1'b0; bus_rdata = IDLE_RDATA;
    chk1("busy_resp", busy, 1'b1);
  endtask

  // Present a request and advance to the first cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd);
    step();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_rd = rd;
    step();
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values while reset is held.
    repeat (2) step();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'(ST_IDLE));
`ifdef LOAD_ADEL_EN
    chk1("rst_exc_adel", exc_adel, 1'b0);
    chk("rst_badvaddr", exc_badvaddr, 32'd0);
`endif
    reset = 1'b1;
    step();

    // Byte loads from offset 3: 0x80 sign- and zero-extended.
    do_load(3'(LD_LB),  32'h0000_0103, 5'd1, 0, 0, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load(3'(LD_LBU), 32'h0000_0103, 5'd2, 0, 0, 32'h80FF_1234, 32'h0000_0080);
    // Upper halfword with two cycles of grant wait.
    do_load(3'(LD_LH),  32'h0000_0102, 5'd3, 2, 0, 32'h9ABC_5678, 32'hFFFF_9ABC);

    // lw flushed in DATA: drained, nothing written back, IDLE after rvalid.
    issue(3'(LD_LW), 32'h0000_0200, 5'd4);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("drain_state", {29'd0, dbg_state}, 32'(ST_DRAIN));
    chk1("drain_busy", busy, 1'b1);
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_rvalid = 1'b0; bus_rdata = IDLE_RDATA;
    chk1("drain_idle_ready", req_ready, 1'b1);
    chk1("drain_idle_busy", busy, 1'b0);
    chk("drain_hold_data", wb_data, 32'hFFFF_9ABC);

    // Flush in ADDR without grant: request dropped.
    issue(3'(LD_LB), 32'h0000_0300, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("flush_addr_bus_req", bus_req, 1'b0);
    chk1("flush_addr_busy", busy, 1'b0);

    // Flush and rvalid together in DATA: data discarded, straight to IDLE.
    issue(3'(LD_LBU), 32'h0000_0301, 5'd6);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    flush = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    step();
    flush = 1'b0; bus_rvalid = 1'b0; bus_rdata = IDLE_RDATA;
    chk1("flush_rv_busy", busy, 1'b0);
    chk("flush_rv_hold_data", wb_data, 32'hFFFF_9ABC);
    chk("flush_rv_hold_rd", {27'd0, wb_rd}, 32'd3);

    // Op none and invalid op 7 are not accepted.
    issue(3'(LD_NONE), 32'h0000_0400, 5'd7);
    chk1("op_none_busy", busy, 1'b0);
    issue(3'd7, 32'h0000_0400, 5'd7);
    chk1("op_inv_busy", busy, 1'b0);

    // Back-to-back: lw then lhu at offset 2.
    do_load(3'(LD_LW),  32'h0000_0000, 5'd8, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load(3'(LD_LHU), 32'h0000_0006, 5'd9, 0, 0, 32'h1234_ABCD, 32'h0000_1234);

    // More lanes and extension cases, one with data wait.
    do_load(3'(LD_LB),  32'h0000_0100, 5'd10, 0, 0, 32'h0000_007F, 32'h0000_007F);
    do_load(3'(LD_LBU), 32'h0000_0101, 5'd11, 1, 0, 32'h0000_FF00, 32'h0000_00FF);
    do_load(3'(LD_LH),  32'h0000_0100, 5'd12, 0, 0, 32'h0000_8001, 32'hFFFF_8001);
    do_load(3'(LD_LHU), 32'h0000_0102, 5'd13, 0, 2, 32'h8000_0000, 32'h0000_8000);
    do_load(3'(LD_LB),  32'h0000_0102, 5'd14, 0, 0, 32'h00C3_0000, 32'hFFFF_FFC3);

`ifdef LOAD_ADEL_EN
    // Misaligned lw: no bus traffic, exception result one cycle after accept.
    begin
      int c0;
      step();
      req_valid = 1'b1; req_op = 3'(LD_LW); req_addr = 32'h0000_0202; req_rd = 5'd15;
      c0 = cyc;
      push_exp(32'd0, 5'd15, c0 + 1, 1'b1);
      step();
      req_valid = 1'b0; req_op = 3'd0;
      chk1("adel_lw_bus_req", bus_req, 1'b0);
      chk("adel_lw_badvaddr", exc_badvaddr, 32'h0000_0202);
      step();
      chk1("adel_lw_bus_req2", bus_req, 1'b0);
      chk1("adel_lw_busy", busy, 1'b0);
      // Misaligned lh.
      req_valid = 1'b1; req_op = 3'(LD_LH); req_addr = 32'h0000_0101; req_rd = 5'd16;
      c0 = cyc;
      push_exp(32'd0, 5'd16, c0 + 1, 1'b1);
      step();
      req_valid = 1'b0; req_op = 3'd0;
      chk1("adel_lh_bus_req", bus_req, 1'b0);
      chk("adel_lh_badvaddr", exc_badvaddr, 32'h0000_0101);
    end
`else
    // Without the check, misaligned addresses are truncated on the bus.
    do_load(3'(LD_LW), 32'h0000_0202, 5'd15, 0, 0, 32'h1122_3344, 32'h1122_3344);
    do_load(3'(LD_LH), 32'h0000_0101, 5'd16, 0, 0, 32'hAABB_CCDD, 32'hFFFF_CCDD);
`endif

    // Reset mid-transaction in DATA, then a late rvalid is ignored.
    issue(3'(LD_LB), 32'h0000_0500, 5'd17);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk1("midrst_req_ready", req_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_bus_req", bus_req, 1'b0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk1("midrst_wb_valid", wb_valid, 1'b0);
    chk("midrst_wb_data", wb_data, 32'd0);
    chk("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
    step();
    reset = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_rvalid = 1'b0; bus_rdata = IDLE_RDATA;
    chk1("late_rv_busy", busy, 1'b0);
    chk("late_rv_wb_data", wb_data, 32'd0);

    // Let any pending response drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    repeat (3) step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
